// File: rtl/c499_sec_pipe_locked.sv
// -----------------------------------------------------------------------------
// c499_sec_pipe_locked
//   Key-locked, two-stage pipelined single-error-correcting (Hamming SEC)
//   datapath with valid/ready handshakes on both sides and saturating error
//   counters.
//
//   Stage 1 unmasks the incoming word with the key register and computes the
//   syndrome. Stage 2 corrects a single data-bit error, or flags a check-bit
//   error or an uncorrectable syndrome. Outputs are driven from registers.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   key_we, key_in      load the unmask key
//   in_valid/in_ready   upstream handshake; in_data masked word, in_chk check
//                       bits, in_chk_en gates in_chk to zero when low
//   out_valid/out_ready downstream handshake; out_data corrected word plus
//                       out_corr / out_chk_err / out_uncorr (one-hot or none)
//   corr_cnt            beats transferred with out_corr or out_chk_err
//   uncorr_cnt          beats transferred with out_uncorr
//   cnt_clr             synchronous clear of both counters (wins over +1)
// -----------------------------------------------------------------------------
module c499_sec_pipe_locked #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [DATA_W-1:0] key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              in_chk_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_chk_err,
  output logic              out_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  input  logic              cnt_clr
);

  // Column of data bit idx: the idx-th integer >= 3 that is not a power of two.
  function automatic logic [CHK_W-1:0] col_of(input int idx);
    logic [CHK_W-1:0] res;
    int               cnt;
    res = {CHK_W{1'b0}};
    cnt = 0;
    for (int v = 3; v < (1 << CHK_W); v++) begin
      if ((v & (v - 1)) != 0) begin
        if (cnt == idx) begin
          res = CHK_W'(v);
        end else begin
          res = res;
        end
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return res;
  endfunction

  // Data-only part of the syndrome: XOR of the columns of all set bits.
  function automatic logic [CHK_W-1:0] data_synd(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] s;
    s = {CHK_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      s = s ^ (d[i] ? col_of(i) : {CHK_W{1'b0}});
    end
    return s;
  endfunction

  logic [DATA_W-1:0] key_r;
  logic              s1_valid_r;
  logic [DATA_W-1:0] s1_d_r;
  logic [CHK_W-1:0]  s1_s_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_corr_r;
  logic              out_chk_err_r;
  logic              out_uncorr_r;
  logic [CNT_W-1:0]  corr_cnt_r;
  logic [CNT_W-1:0]  uncorr_cnt_r;

  logic              s2_adv_s;
  logic              s1_adv_s;
  logic              accept_s;
  logic              xfer_s;
  logic [DATA_W-1:0] d_in_s;
  logic [CHK_W-1:0]  c_in_s;
  logic [CHK_W-1:0]  s_in_s;
  logic [DATA_W-1:0] fix_s;
  logic              corr_s;
  logic              chk_err_s;
  logic              unc_s;

  // Handshake: a stage advances when it is empty or its downstream advances.
  assign s2_adv_s = ~out_valid_r | out_ready;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign in_ready = s1_adv_s;
  assign accept_s = in_valid & s1_adv_s;
  assign xfer_s   = out_valid_r & out_ready;

  // Unmask with the currently held key; a same-cycle key_we affects later beats only.
  assign d_in_s = in_data ^ key_r;
  assign c_in_s = in_chk_en ? in_chk : {CHK_W{1'b0}};
  assign s_in_s = data_synd(d_in_s) ^ c_in_s;

  // Decode the stage-1 syndrome into corrected data and a single flag.
  always_comb begin
    fix_s     = s1_d_r;
    corr_s    = 1'b0;
    chk_err_s = 1'b0;
    unc_s     = 1'b0;
    if (s1_s_r == {CHK_W{1'b0}}) begin
      corr_s = 1'b0;
    end else if ($onehot(s1_s_r)) begin
      chk_err_s = 1'b1;
    end else begin
      // Assume uncorrectable until a data column matches.
      unc_s = 1'b1;
      for (int k = 0; k < DATA_W; k++) begin
        if (s1_s_r == col_of(k)) begin
          fix_s[k] = ~s1_d_r[k];
          corr_s   = 1'b1;
          unc_s    = 1'b0;
        end else begin
          fix_s[k] = s1_d_r[k];
        end
      end
    end
  end

  // Key register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r <= {DATA_W{1'b0}};
    end else if (key_we) begin
      key_r <= key_in;
    end
  end

  // Stage 1: capture unmasked data and syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_d_r     <= {DATA_W{1'b0}};
      s1_s_r     <= {CHK_W{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (accept_s) begin
        s1_d_r <= d_in_s;
        s1_s_r <= s_in_s;
      end
    end
  end

  // Stage 2: capture corrected data and flags; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= {DATA_W{1'b0}};
      out_corr_r    <= 1'b0;
      out_chk_err_r <= 1'b0;
      out_uncorr_r  <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_data_r    <= fix_s;
        out_corr_r    <= corr_s;
        out_chk_err_r <= chk_err_s;
        out_uncorr_r  <= unc_s;
      end
    end
  end

  // Saturating counters, stepped on output transfer; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_r   <= {CNT_W{1'b0}};
      uncorr_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      corr_cnt_r   <= {CNT_W{1'b0}};
      uncorr_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (xfer_s && (out_corr_r || out_chk_err_r) && (corr_cnt_r != {CNT_W{1'b1}})) begin
        corr_cnt_r <= corr_cnt_r + CNT_W'(1);
      end
      if (xfer_s && out_uncorr_r && (uncorr_cnt_r != {CNT_W{1'b1}})) begin
        uncorr_cnt_r <= uncorr_cnt_r + CNT_W'(1);
      end
    end
  end

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_corr    = out_corr_r;
  assign out_chk_err = out_chk_err_r;
  assign out_uncorr  = out_uncorr_r;
  assign corr_cnt    = corr_cnt_r;
  assign uncorr_cnt  = uncorr_cnt_r;

endmodule

// File: tb/tb_c499_sec_pipe_locked.sv
// -----------------------------------------------------------------------------
// Testbench for c499_sec_pipe_locked (DATA_W=32, CHK_W=6, CNT_W=4 so that
// counter saturation is reachable). A queue-based reference model predicts
// every beat leaving the block; directed beats cover the documented examples.
// -----------------------------------------------------------------------------
module tb_c499_sec_pipe_locked;

  localparam int DW = 32;
  localparam int CW = 6;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_we;
  logic [DW-1:0] key_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_chk;
  logic          in_chk_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_corr;
  logic          out_chk_err;
  logic          out_uncorr;
  logic [NW-1:0] corr_cnt;
  logic [NW-1:0] uncorr_cnt;
  logic          cnt_clr;

  c499_sec_pipe_locked #(.DATA_W(DW), .CHK_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chk(in_chk), .in_chk_en(in_chk_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corr(out_corr), .out_chk_err(out_chk_err), .out_uncorr(out_uncorr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          corr;
    logic          chk;
    logic          unc;
  } beat_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  logic [DW-1:0] m_key;
  int    m_corr;
  int    m_unc;
  logic  stall_prev;
  beat_t prev_got;
  logic  last_acc;
  logic  last_in_ready;
  logic [CW-1:0] ref_col [DW];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Syndrome contribution of the data bits alone.
  function automatic logic [CW-1:0] ref_synd(input logic [DW-1:0] d);
    logic [CW-1:0] s = '0;
    for (int i = 0; i < DW; i++) if (d[i]) s ^= ref_col[i];
    return s;
  endfunction

  function automatic beat_t ref_decode(input logic [DW-1:0] d, input logic [CW-1:0] c);
    beat_t e;
    logic [CW-1:0] s;
    s = ref_synd(d) ^ c;
    e = '{data: d, corr: 1'b0, chk: 1'b0, unc: 1'b0};
    if (s != 0) begin
      if ($countones(s) == 1) e.chk = 1'b1;
      else begin
        e.unc = 1'b1;
        for (int i = 0; i < DW; i++)
          if (ref_col[i] == s) begin e.data[i] = ~d[i]; e.corr = 1'b1; e.unc = 1'b0; end
      end
    end
    return e;
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    beat_t got;
    beat_t exp;
    #1;
    got = '{data: out_data, corr: out_corr, chk: out_chk_err, unc: out_uncorr};
    check_val("corr_cnt", corr_cnt, m_corr);
    check_val("uncorr_cnt", uncorr_cnt, m_unc);
    if (stall_prev) begin
      check_val("hold_valid", out_valid, 1);
      check_val("hold_beat", got, prev_got);
    end
    if (out_valid && out_ready) begin
      check_val("beat_expected", exp_q.size() != 0, 1);
      check_val("one_flag", $countones({out_corr, out_chk_err, out_uncorr}) <= 1, 1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check_val("beat", got, exp);
        if (!cnt_clr) begin
          if ((exp.corr || exp.chk) && m_corr < CNT_MAX) m_corr++;
          if (exp.unc && m_unc < CNT_MAX) m_unc++;
        end
      end
    end
    if (cnt_clr) begin m_corr = 0; m_unc = 0; end
    last_in_ready = in_ready;
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(ref_decode(in_data ^ m_key, in_chk_en ? in_chk : '0));
    if (key_we) m_key = key_in;
    stall_prev = out_valid && !out_ready;
    prev_got = got;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_flags", {out_corr, out_chk_err, out_uncorr}, 0);
    check_val("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    exp_q.delete();
    m_key = '0; m_corr = 0; m_unc = 0; stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send a single beat into an idle pipe, check latency and the emerging beat.
  task automatic send_one(input logic [DW-1:0] data, input logic [CW-1:0] chk, input logic en,
                          input logic [DW-1:0] exp_data, input logic [2:0] exp_flags);
    int waits;
    in_valid = 1'b1; in_data = data; in_chk = chk; in_chk_en = en; out_ready = 1'b1;
    cycle();
    check_val("accepted", last_acc, 1);
    in_valid = 1'b0; key_we = 1'b0;
    waits = 0;
    while (!out_valid && waits < 6) begin cycle(); waits++; end
    check_val("latency", waits, 1);
    check_val("dir_data", out_data, exp_data);
    check_val("dir_flags", {out_corr, out_chk_err, out_uncorr}, exp_flags);
    cycle();
  endtask

  // Random beat: correct codeword, then optionally corrupt it.
  task automatic rand_beat();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    d = $urandom;
    c = ref_synd(d);
    case ($urandom_range(0, 5))
      2: d[$urandom_range(0, DW-1)] ^= 1'b1;
      3: c[$urandom_range(0, CW-1)] ^= 1'b1;
      4: begin d[$urandom_range(0, 15)] ^= 1'b1; d[$urandom_range(16, DW-1)] ^= 1'b1; end
      5: c = CW'($urandom);
      default: ;
    endcase
    in_data = d ^ m_key;
    in_chk = c;
  endtask

  initial begin
    logic [DW-1:0] beats [8];
    int v, n, sent, cyc;
    // Column table: integers from 3 upward, skipping powers of two.
    v = 3; n = 0;
    while (n < DW) begin
      if ((v & (v - 1)) != 0) begin ref_col[n] = CW'(v); n++; end
      v++;
    end
    key_we = 0; key_in = '0; in_valid = 0; in_data = '0; in_chk = '0; in_chk_en = 1;
    out_ready = 1; cnt_clr = 0; last_acc = 0; last_in_ready = 0; prev_got = '0;
    @(negedge clk);
    apply_reset();

    send_one(32'h0000_0001, 6'h03, 1'b1, 32'h0000_0001, 3'b000);
    check_val("t1_cnt", {corr_cnt, uncorr_cnt}, 0);
    send_one(32'h0000_0000, 6'h03, 1'b1, 32'h0000_0001, 3'b100);
    check_val("t2_corr_cnt", corr_cnt, 1);
    send_one(32'h0000_0000, 6'h01, 1'b1, 32'h0000_0000, 3'b010);
    send_one(32'h0000_0000, 6'h01, 1'b0, 32'h0000_0000, 3'b000);
    send_one(32'h0000_0000, 6'h30, 1'b1, 32'h0000_0000, 3'b001);
    check_val("t4_uncorr_cnt", uncorr_cnt, 1);
    key_we = 1'b1; key_in = 32'hA5A5_A5A5;
    send_one(32'h0000_0001, 6'h03, 1'b1, 32'h0000_0001, 3'b000);
    send_one(32'hA5A5_A5A4, 6'h03, 1'b1, 32'h0000_0001, 3'b000);

    // Back-to-back beats with the consumer stalled for 3 cycles.
    for (int i = 0; i < 8; i++) beats[i] = $urandom;
    sent = 0; cyc = 0;
    while (sent < 8 && cyc < 40) begin
      out_ready = (cyc >= 3);
      in_valid = 1'b1; in_data = beats[sent] ^ m_key; in_chk = ref_synd(beats[sent]); in_chk_en = 1'b1;
      cycle();
      if (cyc < 2) check_val("t6_ready_early", last_in_ready, 1);
      if (cyc == 2) check_val("t6_ready_full", last_in_ready, 0);
      if (last_acc) sent++;
      cyc++;
    end
    check_val("t6_all_sent", sent, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
    check_val("t6_drained", exp_q.size(), 0);

    // Reset in the middle of a stalled stream.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; out_ready = (i == 1); rand_beat();
      cycle();
    end
    apply_reset();
    send_one(32'h0000_0001, 6'h03, 1'b1, 32'h0000_0001, 3'b000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_chk_en = ($urandom_range(0, 7) != 0);
      key_we = ($urandom_range(0, 15) == 0);
      key_in = $urandom;
      cnt_clr = ($urandom_range(0, 60) == 0);
      rand_beat();
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; key_we = 1'b0; cnt_clr = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
    check_val("final_drained", exp_q.size(), 0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
